// File: rtl/off_on_decoder_pkg.sv
// Shared off/on code-bus definitions: state encodings, bus bit indices.
// The encoder side imports the same package.
package off_on_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OFF  = 2'd1,
    ST_ON   = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int CODE_START = 0;
  localparam int CODE_MARK  = 1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/off_on_timer.sv
// Loadable up-counter with terminal-count flag.
// Used as the OFF timeout timer and the ON hold / dead-time timer.
module off_on_timer #(
  parameter int W = 16
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (!rst_n)    cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= cnt + W'(1);
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/off_on_decoder.sv
// Off/on code-bus decoder driving complementary switch enables.
// Define OFF_ON_DEAD_TIME_EN to insert a break-before-make GAP state.
module off_on_decoder
  import off_on_decoder_pkg::*;
#(
  parameter logic [15:0] ON_HOLD   = 16'd40,
  parameter logic [7:0]  N_CYCLES  = 8'd8,
  parameter logic [15:0] TIMEOUT   = 16'd2000,
  parameter logic [3:0]  DEAD_TIME = 4'd3
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic [1:0] i,
  output logic       off_sw,
  output logic       on_sw,
  output logic [7:0] cycle_cnt,
  output logic       done,
  output logic       err
);

  logic [1:0] i_q;
  logic       start_q_d;
  state_t     state, state_n;

  // Bus regs keep sampling through reset so a start level
  // held across reset is not mistaken for a fresh edge.
  always_ff @(posedge clk_sys) begin
    i_q       <= i;
    start_q_d <= i_q[CODE_START];
  end

  logic start, mark, start_rise;
  assign start      = i_q[CODE_START];
  assign mark       = i_q[CODE_MARK];
  assign start_rise = start & ~start_q_d;

  logic        to_tc, hold_tc;
  logic        to_load, hold_load, hold_en;
  logic [15:0] hold_term;

  assign to_load   = (state != ST_OFF) || (state_n != ST_OFF);
  assign hold_load = (state_n != state);
  assign hold_en   = (state == ST_ON) || (state == ST_GAP);
  assign hold_term = (state == ST_GAP) ? {12'd0, DEAD_TIME - 4'd1}
                                       : ON_HOLD - 16'd1;

  off_on_timer #(.W(16)) u_to_tmr (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .load     (to_load),
    .en       (1'b1),
    .load_val (16'd0),
    .term     (TIMEOUT - 16'd1),
    .tc       (to_tc)
  );

  off_on_timer #(.W(16)) u_hold_tmr (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .load     (hold_load),
    .en       (hold_en),
    .load_val (16'd0),
    .term     (hold_term),
    .tc       (hold_tc)
  );

  logic       err_set, err_clr, cnt_clr, cnt_inc, done_n;
  logic [7:0] cnt_nxt;

  assign cnt_nxt = sat_inc(cycle_cnt);

  always_comb begin
    state_n = state;
    err_set = 1'b0;
    err_clr = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_rise) begin
          state_n = ST_OFF;
          err_clr = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      ST_OFF: begin
        if (!start) begin
          state_n = ST_IDLE;
        end else if (mark) begin
`ifdef OFF_ON_DEAD_TIME_EN
          state_n = ST_GAP;
`else
          state_n = ST_ON;
`endif
        end else if (to_tc) begin
          err_set = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_ON: begin
        if (!start) begin
          state_n = ST_IDLE;
        end else begin
          // Overrun marker is flagged and dropped; hold keeps running.
          err_set = mark;
          if (hold_tc) begin
            cnt_inc = 1'b1;
            if (cycle_cnt != 8'hFF && cnt_nxt == N_CYCLES) begin
              done_n  = 1'b1;
              state_n = ST_IDLE;
            end else begin
              state_n = ST_OFF;
            end
          end
        end
      end
`ifdef OFF_ON_DEAD_TIME_EN
      ST_GAP: begin
        if (!start) begin
          state_n = ST_IDLE;
        end else begin
          err_set = mark;
          if (hold_tc) state_n = ST_ON;
        end
      end
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      off_sw    <= 1'b0;
      on_sw     <= 1'b0;
      cycle_cnt <= 8'd0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state  <= state_n;
      off_sw <= (state_n == ST_OFF);
      on_sw  <= (state_n == ST_ON);
      done   <= done_n;
      if (cnt_clr)      cycle_cnt <= 8'd0;
      else if (cnt_inc) cycle_cnt <= cnt_nxt;
      if (err_clr)      err <= 1'b0;
      else if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_off_on_decoder.sv
// Randomized bench for off_on_decoder against a cycle-level
// behavioural model built on remaining-cycle countdowns.
module tb_off_on_decoder;

  localparam int ON_HOLD  = 40;
  localparam int N_CYC    = 8;
  localparam int TIMEOUT  = 2000;
  localparam int DEAD     = 3;
`ifdef OFF_ON_DEAD_TIME_EN
  localparam bit DT_EN = 1'b1;
`else
  localparam bit DT_EN = 1'b0;
`endif

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b0;
  logic [1:0] i       = 2'b00;
  logic       off_sw, on_sw, done, err;
  logic [7:0] cycle_cnt;

  always #5 clk_sys = ~clk_sys;

  off_on_decoder dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .i         (i),
    .off_sw    (off_sw),
    .on_sw     (on_sw),
    .cycle_cnt (cycle_cnt),
    .done      (done),
    .err       (err)
  );

  int n_chk = 0;
  int n_err = 0;
  int done_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 off, 2 on, 3 gap.
  int         m_mode = 0;
  int         m_rem  = 0;
  int         m_wait = 0;
  int         m_cnt  = 0;
  bit         m_err  = 1'b0;
  bit         m_done = 1'b0;
  logic [1:0] m_q    = 2'b00;
  bit         m_qd   = 1'b0;

  task automatic model_step();
    bit st, mk, rise;
    st   = m_q[0];
    mk   = m_q[1];
    rise = m_q[0] & ~m_qd;
    m_done = 1'b0;
    if (!rst_n) begin
      m_mode = 0; m_cnt = 0; m_err = 1'b0;
      m_rem = 0; m_wait = 0;
    end else begin
      case (m_mode)
        0: if (rise) begin
          m_mode = 1; m_wait = 0; m_cnt = 0; m_err = 1'b0;
        end
        1: begin
          if (!st) m_mode = 0;
          else if (mk) begin
            if (DT_EN) begin m_mode = 3; m_rem = DEAD; end
            else begin m_mode = 2; m_rem = ON_HOLD; end
          end else begin
            m_wait++;
            if (m_wait == TIMEOUT) begin m_err = 1'b1; m_mode = 0; end
          end
        end
        2: begin
          if (!st) m_mode = 0;
          else begin
            if (mk) m_err = 1'b1;
            m_rem--;
            if (m_rem == 0) begin
              if (m_cnt < 255) begin
                m_cnt++;
                m_done = (m_cnt == N_CYC);
              end
              if (m_done) m_mode = 0;
              else begin m_mode = 1; m_wait = 0; end
            end
          end
        end
        default: begin
          if (!st) m_mode = 0;
          else begin
            if (mk) m_err = 1'b1;
            m_rem--;
            if (m_rem == 0) begin m_mode = 2; m_rem = ON_HOLD; end
          end
        end
      endcase
    end
    m_qd = m_q[0];
    m_q  = i;
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_step();
    #1;
    if (done) done_seen++;
    chk("off_sw",    32'(off_sw),      32'(m_mode == 1));
    chk("on_sw",     32'(on_sw),       32'(m_mode == 2));
    chk("cycle_cnt", 32'(cycle_cnt),   32'(m_cnt));
    chk("done",      32'(done),        32'(m_done));
    chk("err",       32'(err),         32'(m_err));
    chk("overlap",   32'(off_sw & on_sw), 32'd0);
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic mark();
    i[1] = 1'b1;
    tick();
    i[1] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    i = 2'b00;
    cycles(3);
    chk("rst_sw",   32'({off_sw, on_sw}), 32'd0);
    chk("rst_cnt",  32'(cycle_cnt), 32'd0);
    chk("rst_flag", 32'({done, err}), 32'd0);
    rst_n = 1'b1;
    cycles(2);

    // nominal sequence
    done_seen = 0;
    i[0] = 1'b1;
    cycles(5);
    for (int k = 0; k < N_CYC; k++) begin
      mark();
      cycles(99);
    end
    chk("nom_cnt",   32'(cycle_cnt), 32'(N_CYC));
    chk("nom_done",  32'(done_seen), 32'd1);
    chk("nom_err",   32'(err), 32'd0);
    chk("nom_idle",  32'({off_sw, on_sw}), 32'd0);

    // timeout
    i[0] = 1'b0;
    cycles(3);
    i[0] = 1'b1;
    cycles(2005);
    chk("to_err", 32'(err), 32'd1);
    chk("to_sw",  32'({off_sw, on_sw}), 32'd0);

    // overrun
    i[0] = 1'b0;
    cycles(2);
    i[0] = 1'b1;
    cycles(4);
    mark();
    cycles(9);
    mark();
    cycles(60);
    chk("ovr_err", 32'(err), 32'd1);
    chk("ovr_cnt", 32'(cycle_cnt), 32'd1);

    // start edge and marker together: marker ignored
    i[0] = 1'b0;
    cycles(2);
    i = 2'b11;
    tick();
    i[1] = 1'b0;
    cycles(3);
    chk("sm_err", 32'(err), 32'd0);
    chk("sm_off", 32'({off_sw, on_sw}), 32'b10);

    // abort during third ON
    done_seen = 0;
    mark();
    cycles(60);
    mark();
    cycles(60);
    mark();
    cycles(10);
    i[0] = 1'b0;
    tick();
    tick();
    chk("abort_sw",  32'({off_sw, on_sw}), 32'd0);
    chk("abort_cnt", 32'(cycle_cnt), 32'd2);
    cycles(5);
    chk("abort_done", 32'(done_seen), 32'd0);
    i[0] = 1'b1;
    cycles(3);
    chk("restart_cnt", 32'(cycle_cnt), 32'd0);
    chk("restart_sw",  32'({off_sw, on_sw}), 32'b10);

    // reset mid-ON, start held high
    cycles(3);
    mark();
    cycles(10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid_sw",  32'({off_sw, on_sw}), 32'd0);
    chk("rst_mid_cnt", 32'(cycle_cnt), 32'd0);
    mark();
    cycles(5);
    mark();
    cycles(50);
    chk("rst_ign_sw", 32'({off_sw, on_sw}), 32'd0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(399) == 0) i[0] = ~i[0];
      i[1] = ($urandom_range(29) == 0);
      rst_n = ($urandom_range(999) != 0);
      tick();
    end
    rst_n = 1'b1;
    i = 2'b00;
    cycles(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
